// File: rtl/qid_lmubuf_pkg.sv
// Shared widths, opcode constants and the entry layout for the QID -> LMU buffer.
package qid_lmubuf_pkg;

  localparam int OPCODE_BW = 4;
  localparam int LQADDR_BW = 5;
  localparam int ENTRY_BW  = OPCODE_BW + LQADDR_BW;

  localparam logic [OPCODE_BW-1:0] LQM_X          = 4'h1;
  localparam logic [OPCODE_BW-1:0] LQM_Y          = 4'h2;
  localparam logic [OPCODE_BW-1:0] LQM_Z          = 4'h3;
  localparam logic [OPCODE_BW-1:0] PPM_INTERPRET  = 4'h8;
  localparam logic [OPCODE_BW-1:0] INVALID_OPCODE = 4'hF;

  // One buffered measurement request.
  typedef struct packed {
    logic [OPCODE_BW-1:0] opcode;
    logic [LQADDR_BW-1:0] mregdst;
  } lmu_entry_t;

endpackage

// File: rtl/qid_lmubuf_mem.sv
// Entry storage: DEPTH slots, one write port, one asynchronous read port.
// Storage is not reset; the control logic never presents an unwritten slot.
module qid_lmubuf_mem
  import qid_lmubuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTR_BW = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_BW-1:0] wr_addr,
  input  lmu_entry_t        wr_data,
  input  logic [PTR_BW-1:0] rd_addr,
  output lmu_entry_t        rd_data
);

  logic [DEPTH-1:0][ENTRY_BW-1:0] slots;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      lmu_entry_t slot_reg;

      // Slot loads only when it is the target of an accepted write.
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == PTR_BW'(gi))) begin
          slot_reg <= wr_data;
        end
      end

      assign slots[gi] = slot_reg;
    end
  endgenerate

  assign rd_data = lmu_entry_t'(slots[rd_addr]);

endmodule

// File: rtl/qid_lmubuf.sv
// Decoupling FIFO between QID and the LMU: QID writes one entry per cycle,
// the LMU drains them in order over a show-ahead valid/ready handshake.
module qid_lmubuf
  import qid_lmubuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTR_BW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 to_lmubuf_valid,
  input  logic [OPCODE_BW-1:0] wr_opcode,
  input  logic [LQADDR_BW-1:0] wr_mregdst,
  output logic                 to_lmubuf_full,
  output logic                 lmu_valid,
  input  logic                 lmu_ready,
  output logic [OPCODE_BW-1:0] lmu_opcode,
  output logic [LQADDR_BW-1:0] lmu_mregdst,
  output logic                 lmubuf_empty,
  output logic [PTR_BW:0]      lmubuf_count,
  output logic                 ovf_err,
  output logic                 unf_err
);

  logic [PTR_BW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_BW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_BW:0]   count_reg,  count_next;
  logic              ovf_err_reg, ovf_err_next;
  logic              unf_err_reg, unf_err_next;

  logic       full, empty, push, pop;
  lmu_entry_t wr_entry, head_entry;

  // Flags come straight from the registered count, so they are glitch-free
  // and settle to reset values as soon as rst_n falls.
  assign full  = (count_reg == (PTR_BW+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // A full buffer rejects a write even if the LMU pops in the same cycle.
  assign push = to_lmubuf_valid & ~full;
  assign pop  = lmu_ready & ~empty;

  assign wr_entry = '{opcode: wr_opcode, mregdst: wr_mregdst};

  qid_lmubuf_mem #(
    .DEPTH  (DEPTH),
    .PTR_BW (PTR_BW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push & ~flush),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_reg),
    .rd_data (head_entry)
  );

  // Next-state: flush wins over any push/pop; errors are sticky until flush/reset.
  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    ovf_err_next = ovf_err_reg | (to_lmubuf_valid & full);
    unf_err_next = unf_err_reg | (lmu_ready & empty);
    if (flush) begin
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      count_next   = '0;
      ovf_err_next = 1'b0;
      unf_err_next = 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push && !pop)      count_next = count_reg + 1'b1;
      else if (pop && !push) count_next = count_reg - 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      ovf_err_reg <= 1'b0;
      unf_err_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      ovf_err_reg <= ovf_err_next;
      unf_err_reg <= unf_err_next;
    end
  end

  assign to_lmubuf_full = full;
  assign lmubuf_empty   = empty;
  assign lmu_valid      = ~empty;
  assign lmubuf_count   = count_reg;
  assign ovf_err        = ovf_err_reg;
  assign unf_err        = unf_err_reg;
  // An empty buffer shows a harmless invalid entry rather than stale storage.
  assign lmu_opcode     = empty ? INVALID_OPCODE : head_entry.opcode;
  assign lmu_mregdst    = empty ? '0 : head_entry.mregdst;

endmodule
